// File: rtl/fifo_ring_if.sv
// Handshake and status bundle for fifo_ring: the producer/consumer side is the
// master; the FIFO is the slave.
interface fifo_ring_if #(
  parameter int WIDTH = 4,
  parameter int LW    = 3
);
  logic [WIDTH-1:0] d_in;
  logic             d_in_strobe;
  logic [WIDTH-1:0] q;
  logic             q_ready;
  logic             q_out_strobe;
  logic             flush;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             underflow;

  modport master (
    output d_in, d_in_strobe, q_out_strobe, flush,
    input  q, q_ready, full, empty, almost_full, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  d_in, d_in_strobe, q_out_strobe, flush,
    output q, q_ready, full, empty, almost_full, almost_empty, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_ring.sv
// Circular-buffer FIFO with occupancy count, almost-full/empty thresholds,
// synchronous flush, sticky error flags and optional pass-through while empty.
module fifo_ring #(
  parameter int WIDTH    = 4,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = 4,
  parameter int AE_LEVEL = 1,
  parameter int BYPASS   = 1,
  parameter int LW       = 3
) (
  input  logic         clk,
  input  logic         rst,
  fifo_ring_if.slave   bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [LW-1:0]    level_r;
  logic             overflow_r, underflow_r;
  logic             full_c, empty_c, byp, rd_acc, rd_pop, wr_acc;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_c = (level_r == '0);
  assign full_c  = (level_r == LW'(DEPTH));

  always_comb begin
    if (empty_c && (BYPASS != 0)) begin
      bus.q       = bus.d_in;
      bus.q_ready = bus.d_in_strobe;
    end else begin
      bus.q       = mem[rd_ptr];
      bus.q_ready = ~empty_c;
    end
  end

  // A bypassed word is consumed straight from d_in, so it neither pops nor pushes.
  assign byp    = (BYPASS != 0) & empty_c & bus.d_in_strobe & bus.q_out_strobe;
  assign rd_acc = bus.q_out_strobe & bus.q_ready;
  assign rd_pop = rd_acc & ~byp;
  assign wr_acc = bus.d_in_strobe & ~byp & (~full_c | rd_acc) & ~bus.flush;

  // NOTE: the storage array carries no reset; contents are meaningless until
  // written, and leaving it out of the reset tree keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.d_in;
  end

  // NOTE: all state updates use non-blocking assignments so every term above
  // sees the pre-edge values of level_r and the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_pop) rd_ptr <= ptr_inc(rd_ptr);
      if (wr_acc && !rd_pop)      level_r <= level_r + LW'(1);
      else if (rd_pop && !wr_acc) level_r <= level_r - LW'(1);
      if (bus.d_in_strobe && full_c && !rd_acc) overflow_r  <= 1'b1;
      if (bus.q_out_strobe && !bus.q_ready)     underflow_r <= 1'b1;
    end
  end

  assign bus.full         = full_c;
  assign bus.empty        = empty_c;
  assign bus.almost_full  = (int'(level_r) >= AF_LEVEL);
  assign bus.almost_empty = (int'(level_r) <= AE_LEVEL);
  assign bus.level        = level_r;
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;
endmodule

// File: tb/tb_fifo_ring.sv
// Directed bench for fifo_ring: one registered instance (BYPASS=0) and one
// pass-through instance (BYPASS=1), both DEPTH=5, WIDTH=4.
module tb_fifo_ring;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run = 0;
  int   failures  = 0;

  always #5 clk = ~clk;

  fifo_ring_if #(.WIDTH(4), .LW(3)) ia ();
  fifo_ring_if #(.WIDTH(4), .LW(3)) ib ();

  fifo_ring #(.WIDTH(4), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .BYPASS(0), .LW(3))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  fifo_ring #(.WIDTH(4), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1), .BYPASS(1), .LW(3))
    dut_b (.clk(clk), .rst(rst), .bus(ib));

  task automatic idle();
    ia.d_in = '0; ia.d_in_strobe = 0; ia.q_out_strobe = 0; ia.flush = 0;
    ib.d_in = '0; ib.d_in_strobe = 0; ib.q_out_strobe = 0; ib.flush = 0;
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    #3;
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL rst_empty: got %b want 1", ia.empty); end
    tests_run++; if (ia.full !== 1'b0) begin failures++; $display("FAIL rst_full: got %b want 0", ia.full); end
    tests_run++; if (ia.almost_empty !== 1'b1) begin failures++; $display("FAIL rst_ae: got %b want 1", ia.almost_empty); end
    tests_run++; if (ia.almost_full !== 1'b0) begin failures++; $display("FAIL rst_af: got %b want 0", ia.almost_full); end
    tests_run++; if (ia.level !== 3'd0) begin failures++; $display("FAIL rst_level: got %0d want 0", ia.level); end
    tests_run++; if ({ia.overflow, ia.underflow} !== 2'b00) begin failures++; $display("FAIL rst_err: got %b want 00", {ia.overflow, ia.underflow}); end
    tests_run++; if (ia.q_ready !== 1'b0) begin failures++; $display("FAIL rst_qready: got %b want 0", ia.q_ready); end
    tests_run++; if (ib.empty !== 1'b1) begin failures++; $display("FAIL rst_b_empty: got %b want 1", ib.empty); end
    #14 rst = 1'b0;
    cycle();
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 5; i++) begin
      ia.d_in = 4'(i); ia.d_in_strobe = 1;
      cycle();
      tests_run++; if (ia.level !== 3'(i)) begin failures++; $display("FAIL fill_level%0d: got %0d want %0d", i, ia.level, i); end
      tests_run++; if (ia.almost_full !== (i >= 4)) begin failures++; $display("FAIL fill_af%0d: got %b want %b", i, ia.almost_full, (i >= 4)); end
      tests_run++; if (ia.almost_empty !== (i <= 1)) begin failures++; $display("FAIL fill_ae%0d: got %b want %b", i, ia.almost_empty, (i <= 1)); end
    end
    tests_run++; if (ia.full !== 1'b1) begin failures++; $display("FAIL fill_full: got %b want 1", ia.full); end
    ia.d_in = 4'd6;
    cycle();
    ia.d_in_strobe = 0;
    tests_run++; if (ia.overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b want 1", ia.overflow); end
    tests_run++; if (ia.level !== 3'd5) begin failures++; $display("FAIL ovf_level: got %0d want 5", ia.level); end
    ia.q_out_strobe = 1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      tests_run++; if (ia.q !== 4'(i)) begin failures++; $display("FAIL drain1_q%0d: got %0d want %0d", i, ia.q, i); end
      cycle();
    end
    ia.q_out_strobe = 0;
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL drain1_empty: got %b want 1", ia.empty); end
    tests_run++; if (ia.overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", ia.overflow); end
  endtask

  task automatic test_full_rw();
    ia.flush = 1;
    cycle();
    ia.flush = 0;
    tests_run++; if (ia.overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf: got %b want 0", ia.overflow); end
    ia.d_in_strobe = 1;
    for (int i = 1; i <= 5; i++) begin
      ia.d_in = 4'(i);
      cycle();
    end
    ia.d_in = 4'd9; ia.q_out_strobe = 1;
    #1;
    tests_run++; if (ia.q !== 4'd1) begin failures++; $display("FAIL fullrw_q: got %0d want 1", ia.q); end
    cycle();
    ia.d_in_strobe = 0;
    tests_run++; if (ia.level !== 3'd5) begin failures++; $display("FAIL fullrw_level: got %0d want 5", ia.level); end
    tests_run++; if (ia.overflow !== 1'b0) begin failures++; $display("FAIL fullrw_ovf: got %b want 0", ia.overflow); end
    for (int i = 0; i < 5; i++) begin
      automatic logic [3:0] exp_q = (i == 4) ? 4'd9 : 4'(i + 2);
      #1;
      tests_run++; if (ia.q !== exp_q) begin failures++; $display("FAIL drain2_q%0d: got %0d want %0d", i, ia.q, exp_q); end
      cycle();
    end
    ia.q_out_strobe = 0;
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL drain2_empty: got %b want 1", ia.empty); end
  endtask

  task automatic test_bypass();
    ib.d_in = 4'hA; ib.d_in_strobe = 1; ib.q_out_strobe = 1;
    #1;
    tests_run++; if (ib.q !== 4'hA) begin failures++; $display("FAIL byp_q: got %0h want a", ib.q); end
    tests_run++; if (ib.q_ready !== 1'b1) begin failures++; $display("FAIL byp_qready: got %b want 1", ib.q_ready); end
    cycle();
    tests_run++; if (ib.level !== 3'd0) begin failures++; $display("FAIL byp_level: got %0d want 0", ib.level); end
    ib.q_out_strobe = 0;
    cycle();
    tests_run++; if (ib.level !== 3'd1) begin failures++; $display("FAIL byp_wr_level: got %0d want 1", ib.level); end
    ib.d_in = 4'hB;
    #1;
    tests_run++; if (ib.q !== 4'hA) begin failures++; $display("FAIL byp_stored_q: got %0h want a", ib.q); end
    cycle();
    ib.d_in_strobe = 0; ib.q_out_strobe = 1;
    for (int i = 0; i < 2; i++) begin
      automatic logic [3:0] exp_q = (i == 0) ? 4'hA : 4'hB;
      #1;
      tests_run++; if (ib.q !== exp_q) begin failures++; $display("FAIL byp_drain_q%0d: got %0h want %0h", i, ib.q, exp_q); end
      cycle();
    end
    ib.q_out_strobe = 0;
    tests_run++; if (ib.empty !== 1'b1) begin failures++; $display("FAIL byp_empty: got %b want 1", ib.empty); end
  endtask

  task automatic test_wrap();
    ia.d_in_strobe = 1;
    for (int n = 0; n < 2; n++) begin
      ia.d_in = 4'(n);
      cycle();
    end
    ia.q_out_strobe = 1;
    for (int k = 0; k < 13; k++) begin
      ia.d_in = 4'(k + 2);
      #1;
      tests_run++; if (ia.q !== 4'(k)) begin failures++; $display("FAIL wrap_q%0d: got %0d want %0d", k, ia.q, k); end
      cycle();
      tests_run++; if (ia.level !== 3'd2) begin failures++; $display("FAIL wrap_level%0d: got %0d want 2", k, ia.level); end
    end
    ia.d_in_strobe = 0;
    for (int k = 13; k < 15; k++) begin
      #1;
      tests_run++; if (ia.q !== 4'(k)) begin failures++; $display("FAIL wrap_tail_q%0d: got %0d want %0d", k, ia.q, k); end
      cycle();
    end
    ia.q_out_strobe = 0;
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL wrap_empty: got %b want 1", ia.empty); end
  endtask

  task automatic test_async_reset();
    ia.d_in_strobe = 1;
    for (int i = 5; i <= 7; i++) begin
      ia.d_in = 4'(i);
      cycle();
    end
    ia.d_in_strobe = 0;
    tests_run++; if (ia.level !== 3'd3) begin failures++; $display("FAIL arst_pre_level: got %0d want 3", ia.level); end
    #1 rst = 1'b1;
    #1;
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL arst_empty: got %b want 1", ia.empty); end
    tests_run++; if (ia.level !== 3'd0) begin failures++; $display("FAIL arst_level: got %0d want 0", ia.level); end
    #1 rst = 1'b0;
    cycle();
    ia.d_in = 4'hC; ia.d_in_strobe = 1;
    cycle();
    ia.d_in_strobe = 0;
    tests_run++; if (ia.q !== 4'hC) begin failures++; $display("FAIL arst_first_q: got %0h want c", ia.q); end
    tests_run++; if (ia.level !== 3'd1) begin failures++; $display("FAIL arst_first_level: got %0d want 1", ia.level); end
    ia.q_out_strobe = 1;
    cycle();
    ia.q_out_strobe = 0;
  endtask

  task automatic test_underflow_flush();
    ia.q_out_strobe = 1;
    cycle();
    ia.q_out_strobe = 0;
    tests_run++; if (ia.underflow !== 1'b1) begin failures++; $display("FAIL unf_set: got %b want 1", ia.underflow); end
    tests_run++; if (ia.level !== 3'd0) begin failures++; $display("FAIL unf_level: got %0d want 0", ia.level); end
    ia.flush = 1; ia.d_in = 4'd3; ia.d_in_strobe = 1; ia.q_out_strobe = 1;
    cycle();
    idle();
    tests_run++; if (ia.underflow !== 1'b0) begin failures++; $display("FAIL flush_unf: got %b want 0", ia.underflow); end
    tests_run++; if (ia.level !== 3'd0) begin failures++; $display("FAIL flush_level: got %0d want 0", ia.level); end
    tests_run++; if (ia.empty !== 1'b1) begin failures++; $display("FAIL flush_empty: got %b want 1", ia.empty); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_rw();
    test_bypass();
    test_wrap();
    test_async_reset();
    test_underflow_flush();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end
endmodule
